// File: rtl/snn_pkg.sv
// Shared widths, default synapse constants and saturating arithmetic for the spiking-neuron blocks.
// Latency: n/a (package).
// Backpressure: n/a (package).
package snn_pkg;

    localparam int CUR_W  = 8;
    localparam int RATE_W = 8;
    localparam int ISI_W  = 16;

    typedef logic [CUR_W-1:0]  cur_t;
    typedef logic [RATE_W-1:0] rate_t;
    typedef logic [ISI_W-1:0]  isi_t;

    localparam cur_t WEIGHT_DEF       = 8'd32;
    localparam int   DECAY_SHIFT_DEF  = 3;
    localparam int   DECAY_PERIOD_DEF = 16;

    function automatic cur_t sat_add8(input cur_t a, input cur_t b);
        logic [CUR_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[CUR_W] ? {CUR_W{1'b1}} : sum[CUR_W-1:0];
    endfunction

    function automatic isi_t sat_inc16(input isi_t a);
        return (a == {ISI_W{1'b1}}) ? a : a + 1'b1;
    endfunction

endpackage

// File: rtl/spike_edge_det.sv
// Rising-edge detector for a spike level; previous level is tracked every cycle.
// Latency: edge pulse is combinational from spike_in against the registered previous level.
// Backpressure: none; caller gates the pulse with its own enable.
module spike_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic spike_in,
    output logic spike_edge
);

    logic spike_prev_q;
    logic spike_prev_d;

    always_comb begin
        spike_prev_d = spike_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spike_prev_q <= 1'b0;
        end else begin
            spike_prev_q <= spike_prev_d;
        end
    end

    assign spike_edge = spike_in & ~spike_prev_q;

endmodule

// File: rtl/spike_decoder.sv
// Decodes a spike train into a decaying synaptic current, a windowed rate and the last inter-spike interval.
// Latency: a spike sampled in cycle t is visible on current/isi/spike_seen after edge t+1.
// Backpressure: none; en=0 freezes all counters and drops spikes.
module spike_decoder
    import snn_pkg::*;
#(
    parameter int   WINDOW       = 1000,
    parameter cur_t WEIGHT       = WEIGHT_DEF,
    parameter int   DECAY_SHIFT  = DECAY_SHIFT_DEF,
    parameter int   DECAY_PERIOD = DECAY_PERIOD_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              spike_in,
    output logic [CUR_W-1:0]  current,
    output logic [RATE_W-1:0] rate,
    output logic              rate_valid,
    output logic [ISI_W-1:0]  isi,
    output logic              spike_seen
);

    localparam int WIN_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam int DEC_W = (DECAY_PERIOD > 1) ? $clog2(DECAY_PERIOD) : 1;
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
    localparam logic [DEC_W-1:0] DEC_LAST = DEC_W'(DECAY_PERIOD - 1);

    logic spike_edge;
    logic spike;

    logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
    logic [DEC_W-1:0] dec_cnt_q, dec_cnt_d;
    cur_t             cur_q, cur_d;
    rate_t            run_q, run_d;
    rate_t            rate_q, rate_d;
    logic             rate_vld_q, rate_vld_d;
    isi_t             isi_cnt_q, isi_cnt_d;
    isi_t             isi_q, isi_d;
    logic             seen_q, seen_d;

    logic  dec_tick;
    cur_t  cur_decayed;
    rate_t run_inc;

    spike_edge_det u_edge (
        .clk        (clk),
        .rst_n      (rst_n),
        .spike_in   (spike_in),
        .spike_edge (spike_edge)
    );

    assign spike = spike_edge & en;

    // Decay floors at small values: cur >> DECAY_SHIFT is zero below 2^DECAY_SHIFT.
    always_comb begin
        dec_tick    = (dec_cnt_q == DEC_LAST);
        cur_decayed = dec_tick ? (cur_q - (cur_q >> DECAY_SHIFT)) : cur_q;
        run_inc     = spike ? sat_add8(run_q, 8'd1) : run_q;
    end

    always_comb begin
        win_cnt_d  = win_cnt_q;
        dec_cnt_d  = dec_cnt_q;
        cur_d      = cur_q;
        run_d      = run_q;
        rate_d     = rate_q;
        rate_vld_d = 1'b0;
        isi_cnt_d  = isi_cnt_q;
        isi_d      = isi_q;
        seen_d     = 1'b0;

        if (en) begin
            dec_cnt_d = dec_tick ? '0 : dec_cnt_q + 1'b1;
            cur_d     = spike ? sat_add8(cur_decayed, WEIGHT) : cur_decayed;
            seen_d    = spike;

            // A spike on the terminal cycle is folded into the window that is closing.
            if (win_cnt_q == WIN_LAST) begin
                win_cnt_d  = '0;
                rate_d     = run_inc;
                rate_vld_d = 1'b1;
                run_d      = '0;
            end else begin
                win_cnt_d  = win_cnt_q + 1'b1;
                run_d      = run_inc;
            end

            if (spike) begin
                isi_d     = sat_inc16(isi_cnt_q);
                isi_cnt_d = '0;
            end else begin
                isi_cnt_d = sat_inc16(isi_cnt_q);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_cnt_q  <= '0;
            dec_cnt_q  <= '0;
            cur_q      <= '0;
            run_q      <= '0;
            rate_q     <= '0;
            rate_vld_q <= 1'b0;
            isi_cnt_q  <= '0;
            isi_q      <= '0;
            seen_q     <= 1'b0;
        end else begin
            win_cnt_q  <= win_cnt_d;
            dec_cnt_q  <= dec_cnt_d;
            cur_q      <= cur_d;
            run_q      <= run_d;
            rate_q     <= rate_d;
            rate_vld_q <= rate_vld_d;
            isi_cnt_q  <= isi_cnt_d;
            isi_q      <= isi_d;
            seen_q     <= seen_d;
        end
    end

    assign current    = cur_q;
    assign rate       = rate_q;
    assign rate_valid = rate_vld_q;
    assign isi        = isi_q;
    assign spike_seen = seen_q;

endmodule

// File: tb/tb_spike_decoder.sv
// Self-checking bench for spike_decoder against a timeline-based reference model.
module tb_spike_decoder;

    localparam int WIN = 16;
    localparam int PER = 16;
    localparam int SH  = 3;
    localparam int WT  = 32;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        spike_in;
    logic [7:0]  current;
    logic [7:0]  rate;
    logic        rate_valid;
    logic [15:0] isi;
    logic        spike_seen;

    int n_checks = 0;
    int n_errors = 0;

    // Model: m_e is the index of the next enabled cycle since reset.
    int m_e, m_last, m_wcnt, m_cur, m_rate, m_isi;
    bit m_rv, m_seen, m_prev;

    spike_decoder #(
        .WINDOW       (WIN),
        .WEIGHT       (8'(WT)),
        .DECAY_SHIFT  (SH),
        .DECAY_PERIOD (PER)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .spike_in   (spike_in),
        .current    (current),
        .rate       (rate),
        .rate_valid (rate_valid),
        .isi        (isi),
        .spike_seen (spike_seen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic model_reset();
        m_e = 0; m_last = -1; m_wcnt = 0; m_cur = 0; m_rate = 0; m_isi = 0;
        m_rv = 0; m_seen = 0; m_prev = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; en = 1'b0; spike_in = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    // Drives one cycle, advances the model over the same edge, returns #1 after the edge.
    task automatic step(input bit en_v, input bit sp_v);
        bit ev;
        @(negedge clk);
        en = en_v; spike_in = sp_v;
        @(posedge clk);
        ev = sp_v && !m_prev;
        m_prev = sp_v;
        if (en_v) begin
            if (m_e % PER == PER - 1) m_cur = m_cur - m_cur / (1 << SH);
            if (ev) begin
                m_cur  = (m_cur + WT > 255) ? 255 : m_cur + WT;
                m_isi  = (m_e - m_last > 65535) ? 65535 : m_e - m_last;
                m_last = m_e;
                m_wcnt++;
            end
            if (m_e % WIN == WIN - 1) begin
                m_rate = (m_wcnt > 255) ? 255 : m_wcnt;
                m_rv   = 1;
                m_wcnt = 0;
            end else begin
                m_rv = 0;
            end
            m_seen = ev;
            m_e++;
        end else begin
            m_rv = 0; m_seen = 0;
        end
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_checks++; if (current !== 8'd0) begin n_errors++; $display("FAIL reset_current: got %0d want 0", current); end
        n_checks++; if (rate !== 8'd0) begin n_errors++; $display("FAIL reset_rate: got %0d want 0", rate); end
        n_checks++; if (rate_valid !== 1'b0) begin n_errors++; $display("FAIL reset_rate_valid: got %0b want 0", rate_valid); end
        n_checks++; if (isi !== 16'd0) begin n_errors++; $display("FAIL reset_isi: got %0d want 0", isi); end
        n_checks++; if (spike_seen !== 1'b0) begin n_errors++; $display("FAIL reset_spike_seen: got %0b want 0", spike_seen); end
    endtask

    task automatic test_single_spike();
        int exp_tr[15] = '{28, 25, 22, 20, 18, 16, 14, 13, 12, 11, 10, 9, 8, 7, 7};
        int g;
        do_reset();
        repeat (10) step(1, 0);
        step(1, 1);
        n_checks++; if (spike_seen !== 1'b1) begin n_errors++; $display("FAIL single_seen: got %0b want 1", spike_seen); end
        n_checks++; if (current !== 8'd32) begin n_errors++; $display("FAIL single_current: got %0d want 32", current); end
        step(1, 1);
        n_checks++; if (spike_seen !== 1'b0) begin n_errors++; $display("FAIL single_level_held: got seen=%0b want 0", spike_seen); end
        for (int k = 0; k < 15; k++) begin
            g = 0;
            do begin step(1, 0); g++; end while ((m_e % PER) != 0 && g < 40);
            n_checks++;
            if (current !== 8'(exp_tr[k]))
                begin n_errors++; $display("FAIL decay_tick%0d: got %0d want %0d", k, current, exp_tr[k]); end
        end
    endtask

    task automatic test_rate_window();
        int pulses;
        do_reset();
        pulses = 0;
        for (int o = 0; o < WIN; o++) begin
            step(1, (o == 1 || o == 4 || o == 7 || o == 10 || o == 15));
            if (rate_valid === 1'b1) pulses++;
        end
        n_checks++; if (pulses != 1) begin n_errors++; $display("FAIL rate_pulses_w1: got %0d want 1", pulses); end
        n_checks++; if (rate !== 8'd5) begin n_errors++; $display("FAIL rate_w1: got %0d want 5", rate); end
        pulses = 0;
        for (int o = 0; o < WIN; o++) begin
            step(1, 0);
            if (rate_valid === 1'b1) pulses++;
            if (o == 7) begin
                n_checks++; if (rate !== 8'd5) begin n_errors++; $display("FAIL rate_hold: got %0d want 5", rate); end
            end
        end
        n_checks++; if (pulses != 1) begin n_errors++; $display("FAIL rate_pulses_w2: got %0d want 1", pulses); end
        n_checks++; if (rate !== 8'd0) begin n_errors++; $display("FAIL rate_silent: got %0d want 0", rate); end
    endtask

    task automatic test_reset_async();
        do_reset();
        for (int o = 0; o < WIN; o++) step(1, (o % 2 == 0) && o <= 8);
        step(1, 1); step(1, 0); step(1, 1);
        n_checks++; if (current !== 8'd204 || rate !== 8'd5)
            begin n_errors++; $display("FAIL prereset_state: got cur=%0d rate=%0d want 204/5", current, rate); end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({current, rate, rate_valid, isi, spike_seen} !== 34'd0)
            begin n_errors++; $display("FAIL async_reset: got cur=%0d rate=%0d rv=%0b isi=%0d seen=%0b want all 0", current, rate, rate_valid, isi, spike_seen); end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_coincidence();
        int g;
        do_reset();
        step(1, 1);
        g = 0;
        do begin step(1, 0); g++; end while (m_cur != 9 && g < 400);
        n_checks++; if (current !== 8'd9) begin n_errors++; $display("FAIL coin_floor9: got %0d want 9", current); end
        step(1, 1);
        g = 0;
        do begin step(1, 0); g++; end while ((m_e % PER) != 0 && g < 40);
        n_checks++; if (current !== 8'd36) begin n_errors++; $display("FAIL coin_36: got %0d want 36", current); end
        step(1, 1); step(1, 0); step(1, 1);
        g = 0;
        do begin step(1, 0); g++; end while ((m_e % PER) != PER - 1 && g < 40);
        n_checks++; if (current !== 8'd100) begin n_errors++; $display("FAIL coin_100: got %0d want 100", current); end
        step(1, 1);
        n_checks++; if (current !== 8'd120) begin n_errors++; $display("FAIL coin_spike_on_tick: got %0d want 120", current); end
    endtask

    task automatic test_enable_isi();
        logic [7:0]  cap_cur, cap_rate;
        logic [15:0] cap_isi;
        do_reset();
        repeat (20) step(1, 0);
        step(1, 1);
        n_checks++; if (isi !== 16'(m_isi)) begin n_errors++; $display("FAIL isi_first: got %0d want %0d", isi, m_isi); end
        repeat (36) step(1, 0);
        step(1, 1);
        n_checks++; if (isi !== 16'd37) begin n_errors++; $display("FAIL isi_37: got %0d want 37", isi); end
        step(1, 0); step(1, 0);
        cap_cur = current; cap_rate = rate; cap_isi = isi;
        for (int c = 0; c < 21; c++) begin
            step(0, c >= 5);
            n_checks++;
            if (spike_seen !== 1'b0 || rate_valid !== 1'b0 || current !== cap_cur || rate !== cap_rate || isi !== cap_isi)
                begin n_errors++; $display("FAIL en_off_hold c=%0d: got seen=%0b rv=%0b cur=%0d rate=%0d isi=%0d want 0/0/%0d/%0d/%0d", c, spike_seen, rate_valid, current, rate, isi, cap_cur, cap_rate, cap_isi); end
        end
        for (int c = 0; c < 4; c++) begin
            step(1, 1);
            n_checks++;
            if (spike_seen !== 1'b0 || isi !== cap_isi)
                begin n_errors++; $display("FAIL reenable_no_edge c=%0d: got seen=%0b isi=%0d want 0/%0d", c, spike_seen, isi, cap_isi); end
        end
    endtask

    task automatic test_saturation();
        int maxc;
        do_reset();
        maxc = 0;
        for (int c = 0; c < 64; c++) begin
            step(1, (c % 4) < 2);
            if (int'(current) > maxc) maxc = int'(current);
            n_checks++;
            if ({current, rate, rate_valid, isi, spike_seen} !== {8'(m_cur), 8'(m_rate), m_rv, 16'(m_isi), m_seen})
                begin n_errors++; $display("FAIL sat c=%0d: got cur=%0d rate=%0d rv=%0b isi=%0d seen=%0b want %0d/%0d/%0b/%0d/%0b", c, current, rate, rate_valid, isi, spike_seen, m_cur, m_rate, m_rv, m_isi, m_seen); end
        end
        n_checks++; if (maxc != 255) begin n_errors++; $display("FAIL sat_peak: got %0d want 255", maxc); end
    endtask

    task automatic test_random();
        bit e_v, s_v;
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            e_v = ($urandom_range(0, 9) != 0);
            s_v = ($urandom_range(0, 2) == 0);
            step(e_v, s_v);
            n_checks++;
            if ({current, rate, rate_valid, isi, spike_seen} !== {8'(m_cur), 8'(m_rate), m_rv, 16'(m_isi), m_seen})
                begin n_errors++; $display("FAIL random c=%0d: got cur=%0d rate=%0d rv=%0b isi=%0d seen=%0b want %0d/%0d/%0b/%0d/%0b", c, current, rate, rate_valid, isi, spike_seen, m_cur, m_rate, m_rv, m_isi, m_seen); end
        end
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; spike_in = 1'b0;
        model_reset();
        test_reset();
        test_single_spike();
        test_rate_window();
        test_reset_async();
        test_coincidence();
        test_enable_isi();
        test_saturation();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
